// File: rtl/reg_op_sequencer.sv
// Sequences single-register micro-ops (transfer/inc/dec/load-imm) over the A/X/Y/S bank and produces N/Z flag updates.
// Optional op counter output enabled by defining REG_OP_SEQ_STATS_EN.
module reg_op_sequencer #(
  parameter int NUM_REGS = 4,
  parameter int WIDTH    = 8,
  parameter int SP_INDEX = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [1:0]                cmd_src,
  input  logic [1:0]                cmd_dst,
  input  logic [WIDTH-1:0]          cmd_imm,
  input  logic [NUM_REGS*WIDTH-1:0] reg_q,
  output logic [WIDTH-1:0]          reg_d,
  output logic [NUM_REGS-1:0]       reg_load,
  output logic [NUM_REGS-1:0]       reg_inc,
  output logic [NUM_REGS-1:0]       reg_dec,
  output logic                      flag_n,
  output logic                      flag_z,
  output logic                      flag_we,
  output logic                      done
`ifdef REG_OP_SEQ_STATS_EN
  ,
  output logic [15:0]               op_count
`endif
);

  localparam logic [1:0] OP_TRANSFER = 2'd0;
  localparam logic [1:0] OP_INC      = 2'd1;
  localparam logic [1:0] OP_DEC      = 2'd2;
  localparam logic [1:0] OP_LOAD_IMM = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [1:0]          op_q, src_q, dst_q;
  logic [WIDTH-1:0]    imm_q;
  logic                flag_n_q, flag_z_q;
  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [WIDTH-1:0]    result;
  logic [NUM_REGS-1:0] dst_hot;
  logic                flag_upd;
  logic                accept;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs[i] = reg_q[i*WIDTH +: WIDTH];
    end
  end

  assign accept   = cmd_valid && (state == IDLE);
  assign result   = regs[dst_q];
  assign dst_hot  = NUM_REGS'(1) << dst_q;
  // Transfers into the stack pointer leave P untouched (TXS does not set flags).
  assign flag_upd = !((op_q == OP_TRANSFER) && (int'(dst_q) == SP_INDEX));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      imm_q    <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= cmd_op;
        src_q <= cmd_src;
        dst_q <= cmd_dst;
        imm_q <= cmd_imm;
      end
      if ((state == WB) && flag_upd) begin
        flag_n_q <= result[WIDTH-1];
        flag_z_q <= (result == '0);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Everything is gated by reset so an aborted op emits no strobe on the reset cycle.
  always_comb begin
    cmd_ready = (state == IDLE);
    reg_d     = '0;
    reg_load  = '0;
    reg_inc   = '0;
    reg_dec   = '0;
    flag_n    = flag_n_q;
    flag_z    = flag_z_q;
    flag_we   = 1'b0;
    done      = 1'b0;
    if (reset) begin
      flag_n = 1'b0;
      flag_z = 1'b0;
    end else begin
      case (state)
        EXEC: begin
          case (op_q)
            OP_TRANSFER: begin
              reg_load = dst_hot;
              reg_d    = regs[src_q];
            end
            OP_INC:      reg_inc = dst_hot;
            OP_DEC:      reg_dec = dst_hot;
            OP_LOAD_IMM: begin
              reg_load = dst_hot;
              reg_d    = imm_q;
            end
            default: ;
          endcase
        end
        WB: begin
          done = 1'b1;
          if (flag_upd) begin
            flag_we = 1'b1;
            flag_n  = result[WIDTH-1];
            flag_z  = (result == '0);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REG_OP_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= '0;
    end else if (done && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench for reg_op_sequencer: a behavioural register bank answers the strobes,
// a table of directed ops, hand-written multi-cycle sequences and random ops checked against a model.
module tb_reg_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op, cmd_src, cmd_dst;
  logic [7:0]  cmd_imm;
  logic [31:0] reg_q;
  logic [7:0]  reg_d;
  logic [3:0]  reg_load, reg_inc, reg_dec;
  logic        flag_n, flag_z, flag_we, done;
`ifdef REG_OP_SEQ_STATS_EN
  logic [15:0] op_count;
`endif

  int checks   = 0;
  int failures = 0;

  // register bank seen by the sequencer, with a preset path for setting up scenarios
  logic [7:0] bank [4];
  logic       preset_en = 1'b0;
  logic [1:0] preset_idx = 2'd0;
  logic [7:0] preset_val = 8'd0;

  // reference model state
  logic [7:0] m [4];
  logic       m_n, m_z;
  int         ops_since_reset;

  always #5 clk = ~clk;

  reg_op_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_src  (cmd_src),
    .cmd_dst  (cmd_dst),
    .cmd_imm  (cmd_imm),
    .reg_q    (reg_q),
    .reg_d    (reg_d),
    .reg_load (reg_load),
    .reg_inc  (reg_inc),
    .reg_dec  (reg_dec),
    .flag_n   (flag_n),
    .flag_z   (flag_z),
    .flag_we  (flag_we),
    .done     (done)
`ifdef REG_OP_SEQ_STATS_EN
    ,
    .op_count (op_count)
`endif
  );

  assign reg_q = {bank[3], bank[2], bank[1], bank[0]};

  always @(posedge clk) begin
    if (preset_en) begin
      bank[preset_idx] <= preset_val;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (reg_load[i])     bank[i] <= reg_d;
        else if (reg_inc[i]) bank[i] <= bank[i] + 8'd1;
        else if (reg_dec[i]) bank[i] <= bank[i] - 8'd1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [1:0] src,
                               input logic [1:0] dst, input logic [7:0] imm);
    cmd_valid = v;
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_imm   = imm;
  endtask

  task automatic preset(input logic [1:0] idx, input logic [7:0] val);
    preset_en  = 1'b1;
    preset_idx = idx;
    preset_val = val;
    @(negedge clk);
    preset_en  = 1'b0;
    m[idx]     = val;
  endtask

  // Issue one op from IDLE (called at a negedge) and check every cycle against the model;
  // returns what the DUT showed in its write-back cycle.
  task automatic run_op(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                        input logic [7:0] imm, output logic [7:0] wb_val,
                        output logic wb_n, output logic wb_z, output logic wb_we);
    logic [7:0] nv, exp_d;
    logic [3:0] hot, e_load, e_inc, e_dec;
    logic       upd;
    hot    = 4'b0001 << dst;
    e_load = 4'b0;
    e_inc  = 4'b0;
    e_dec  = 4'b0;
    exp_d  = 8'h00;
    case (op)
      2'd0: begin nv = m[src];        e_load = hot; exp_d = m[src]; end
      2'd1: begin nv = m[dst] + 8'd1; e_inc  = hot; end
      2'd2: begin nv = m[dst] - 8'd1; e_dec  = hot; end
      default: begin nv = imm;        e_load = hot; exp_d = imm; end
    endcase
    upd = !(op == 2'd0 && dst == 2'd3);

    checkOutput("idle_ready", {31'b0, cmd_ready}, 32'd1);
    applyStimulus(1'b1, op, src, dst, imm);
    @(negedge clk);
    applyStimulus(1'b0, 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
    #1;
    checkOutput("exec_ready", {31'b0, cmd_ready}, 32'd0);
    checkOutput("exec_load", {28'b0, reg_load}, {28'b0, e_load});
    checkOutput("exec_inc", {28'b0, reg_inc}, {28'b0, e_inc});
    checkOutput("exec_dec", {28'b0, reg_dec}, {28'b0, e_dec});
    checkOutput("exec_reg_d", {24'b0, reg_d}, {24'b0, exp_d});
    checkOutput("exec_done_we", {30'b0, done, flag_we}, 32'd0);

    m[dst] = nv;
    if (upd) begin
      m_n = nv[7];
      m_z = (nv == 8'h00);
    end
    ops_since_reset++;

    @(negedge clk);
    wb_val = bank[dst];
    wb_n   = flag_n;
    wb_z   = flag_z;
    wb_we  = flag_we;
    checkOutput("wb_value", {24'b0, bank[dst]}, {24'b0, nv});
    checkOutput("wb_ready", {31'b0, cmd_ready}, 32'd0);
    checkOutput("wb_done", {31'b0, done}, 32'd1);
    checkOutput("wb_flag_we", {31'b0, flag_we}, {31'b0, upd});
    checkOutput("wb_flags", {30'b0, flag_n, flag_z}, {30'b0, m_n, m_z});
    checkOutput("wb_no_strobe", {20'b0, reg_load, reg_inc, reg_dec}, 32'd0);
    checkOutput("wb_reg_d", {24'b0, reg_d}, 32'd0);

    @(negedge clk);
    checkOutput("post_done_we", {30'b0, done, flag_we}, 32'd0);
    checkOutput("post_flags_held", {30'b0, flag_n, flag_z}, {30'b0, m_n, m_z});
  endtask

  typedef struct {
    logic       pre_en;
    logic [1:0] pre_idx;
    logic [7:0] pre_val;
    logic [1:0] op, src, dst;
    logic [7:0] imm;
    logic [7:0] exp_val;
    logic       exp_n, exp_z, exp_we;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [7:0] wv;
    logic       wn, wz, wwe;

    vecs[0] = '{1'b1, 2'd1, 8'h00, 2'd2, 2'd0, 2'd1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1}; // DEC X 00->FF
    vecs[1] = '{1'b1, 2'd0, 8'h80, 2'd0, 2'd0, 2'd1, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1}; // TAX 0x80
    vecs[2] = '{1'b1, 2'd1, 8'h00, 2'd0, 2'd1, 2'd3, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}; // TXS keeps flags
    vecs[3] = '{1'b1, 2'd2, 8'hFF, 2'd1, 2'd0, 2'd2, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1}; // INC Y FF->00
    vecs[4] = '{1'b0, 2'd0, 8'h00, 2'd3, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1}; // LDA #0
    vecs[5] = '{1'b1, 2'd3, 8'h7F, 2'd1, 2'd0, 2'd3, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1}; // INC S updates flags
    vecs[6] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd2, 2'd2, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1}; // TYY src==dst
    vecs[7] = '{1'b0, 2'd0, 8'h00, 2'd3, 2'd0, 2'd3, 8'h42, 8'h42, 1'b0, 1'b0, 1'b1}; // LOAD_IMM S
    vecs[8] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 2'd0, 8'h00, 8'h42, 1'b0, 1'b0, 1'b1}; // TSA
    vecs[9] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd0, 2'd0, 8'h00, 8'h41, 1'b0, 1'b0, 1'b1}; // DEC A

    for (int i = 0; i < 4; i++) begin
      bank[i] = 8'h00;
      m[i]    = 8'h00;
    end
    m_n = 1'b0;
    m_z = 1'b0;
    ops_since_reset = 0;
    applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 8'h00);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_ready", {31'b0, cmd_ready}, 32'd1);
    checkOutput("rst_strobes", {20'b0, reg_load, reg_inc, reg_dec}, 32'd0);
    checkOutput("rst_reg_d", {24'b0, reg_d}, 32'd0);
    checkOutput("rst_flags", {28'b0, flag_n, flag_z, flag_we, done}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre_en) preset(vecs[i].pre_idx, vecs[i].pre_val);
      run_op(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].imm, wv, wn, wz, wwe);
      checkOutput($sformatf("tbl%0d_val", i), {24'b0, wv}, {24'b0, vecs[i].exp_val});
      checkOutput($sformatf("tbl%0d_nzwe", i), {29'b0, wn, wz, wwe},
                  {29'b0, vecs[i].exp_n, vecs[i].exp_z, vecs[i].exp_we});
    end

    // back-to-back INC A with cmd_valid held high: ready 1,0,0 and done every third cycle
    preset(2'd0, 8'h01);
    applyStimulus(1'b1, 2'd1, 2'd0, 2'd0, 8'h00);
    for (int c = 0; c < 9; c++) begin
      #1;
      checkOutput($sformatf("b2b_ready%0d", c), {31'b0, cmd_ready}, {31'b0, (c % 3) == 0});
      checkOutput($sformatf("b2b_done%0d", c), {31'b0, done}, {31'b0, (c % 3) == 2});
      if ((c % 3) == 2) begin
        checkOutput($sformatf("b2b_a%0d", c), {24'b0, bank[0]}, 32'(8'h02 + 8'(c / 3)));
        applyStimulus(c != 8, 2'd1, 2'd0, 2'd0, 8'h00);
      end
      @(negedge clk);
    end
    m[0] = 8'h04;
    m_n  = 1'b0;
    m_z  = 1'b0;
    ops_since_reset += 3;
    checkOutput("b2b_idle", {31'b0, cmd_ready}, 32'd1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0) preset(2'($urandom), 8'($urandom));
      run_op(2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), wv, wn, wz, wwe);
    end

`ifdef REG_OP_SEQ_STATS_EN
    checkOutput("op_count", {16'b0, op_count}, 32'(ops_since_reset));
`endif

    // reset during EXEC aborts the op: no strobe now or on the next cycle, flags cleared
    run_op(2'd3, 2'd0, 2'd0, 8'h80, wv, wn, wz, wwe);
    applyStimulus(1'b1, 2'd1, 2'd0, 2'd1, 8'h00);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 8'h00);
    #1;
    checkOutput("abort_exec_inc", {28'b0, reg_inc}, 32'b0010);
    reset = 1'b1;
    #1;
    checkOutput("abort_rst_cycle", {20'b0, reg_load, reg_inc, reg_dec}, 32'd0);
    checkOutput("abort_rst_flags", {28'b0, flag_n, flag_z, flag_we, done}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("abort_next_strobes", {20'b0, reg_load, reg_inc, reg_dec}, 32'd0);
    checkOutput("abort_ready", {31'b0, cmd_ready}, 32'd1);
    checkOutput("abort_flags", {28'b0, flag_n, flag_z, flag_we, done}, 32'd0);
    reset = 1'b0;
    m_n = 1'b0;
    m_z = 1'b0;
    ops_since_reset = 0;
    @(negedge clk);
    checkOutput("abort_after_strobes", {20'b0, reg_load, reg_inc, reg_dec}, 32'd0);
    checkOutput("abort_x_unchanged", {24'b0, bank[1]}, {24'b0, m[1]});
    checkOutput("abort_idle_flags", {29'b0, flag_n, flag_z, done}, 32'd0);
`ifdef REG_OP_SEQ_STATS_EN
    checkOutput("op_count_rst", {16'b0, op_count}, 32'd0);
`endif
    run_op(2'd1, 2'd0, 2'd1, 8'h00, wv, wn, wz, wwe);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
